// File: rtl/sram_ctrl.sv
// sram_ctrl: owns the asynchronous 16-bit SRAM bus and shares it between a
// read port (pixel fetch) and a write port (framebuffer). Every bus signal is
// registered so WE/OE/ADDR/DATA change only on clock edges, and an IDLE cycle
// always separates two accesses for bus turnaround.
//
// state    | meaning
// IDLE     | bus quiet (WE=1, OE=1, data released); arbitration happens here
// RD       | OE low for RD_WAIT cycles; data sampled on the last edge
// WR_SETUP | address/data driven, WE still high
// WR_PULSE | WE low for WR_WAIT cycles, data driven
// WR_HOLD  | WE back high, data still driven for hold time
module sram_ctrl #(
  parameter int unsigned RD_WAIT      = 1,
  parameter int unsigned WR_WAIT      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rd_req_i,
  input  logic [19:0] rd_addr_i,
  output logic        rd_ack_o,
  output logic [15:0] rd_data_o,
  output logic        rd_valid_o,
  input  logic        wr_req_i,
  input  logic [19:0] wr_addr_i,
  input  logic [15:0] wr_data_i,
  output logic        wr_ack_o,
  output logic        sram_we_o,
  output logic        sram_oe_o,
  output logic [19:0] sram_addr_o,
  inout  wire  [15:0] sram_data_io
);

  localparam int unsigned MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int unsigned WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam int unsigned STRK_W   = $clog2(STARVE_LIMIT + 1);

  localparam logic [WAIT_W-1:0] RD_LOAD  = WAIT_W'(RD_WAIT - 1);
  localparam logic [WAIT_W-1:0] WR_LOAD  = WAIT_W'(WR_WAIT - 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_e;

  state_e             state_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [STRK_W-1:0]  streak_q;
  logic [15:0]        wdata_q;
  logic               drive_q;
  logic               rd_ack_q;
  logic               wr_ack_q;
  logic               rd_valid_q;
  logic [15:0]        rd_data_q;
  logic               we_q;
  logic               oe_q;
  logic [19:0]        addr_q;
  logic               grant_wr;
  logic               grant_rd;

  // Write wins only when reads are idle or have starved it for STARVE_LIMIT grants.
  always_comb begin
    grant_wr = wr_req_i && (!rd_req_i || (streak_q == STRK_MAX));
    grant_rd = rd_req_i && !grant_wr;
  end

  assign sram_data_io = drive_q ? wdata_q : {16{1'bz}};
  assign rd_ack_o     = rd_ack_q;
  assign wr_ack_o     = wr_ack_q;
  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = rd_data_q;
  assign sram_we_o    = we_q;
  assign sram_oe_o    = oe_q;
  assign sram_addr_o  = addr_q;

  // Access sequencer: arbitration, bus strobes and handshake pulses, all registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      streak_q   <= '0;
      wdata_q    <= '0;
      drive_q    <= 1'b0;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      we_q       <= 1'b1;
      oe_q       <= 1'b1;
      addr_q     <= '0;
    end else begin
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_wr) begin
            addr_q   <= wr_addr_i;
            wdata_q  <= wr_data_i;
            wr_ack_q <= 1'b1;
            streak_q <= '0;
            drive_q  <= 1'b1;
            state_q  <= WR_SETUP;
          end else if (grant_rd) begin
            addr_q   <= rd_addr_i;
            rd_ack_q <= 1'b1;
            oe_q     <= 1'b0;
            wait_q   <= RD_LOAD;
            if (wr_req_i && (streak_q != STRK_MAX)) begin
              streak_q <= streak_q + 1'b1;
            end
            state_q  <= RD;
          end
        end
        RD: begin
          if (wait_q == '0) begin
            rd_data_q  <= sram_data_io;
            oe_q       <= 1'b1;
            rd_valid_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        WR_SETUP: begin
          we_q    <= 1'b0;
          wait_q  <= WR_LOAD;
          state_q <= WR_PULSE;
        end
        WR_PULSE: begin
          if (wait_q == '0) begin
            we_q    <= 1'b1;
            state_q <= WR_HOLD;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        WR_HOLD: begin
          drive_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          we_q    <= 1'b1;
          oe_q    <= 1'b1;
          drive_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
